// File: rtl/spi_pkg.sv
// Frame layout and FSM encoding shared by the SPI controller and memory target.
// Frames are LSB-first: mode bit, then 8 address bits, then 8 data bits on writes.
package spi_pkg;

  localparam int   FRAME_HDR_BITS = 9;
  localparam int   DATA_BITS      = 8;
  localparam logic MODE_WR        = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RX_HDR,
    RX_DATA,
    COMMIT,
    RD_WAIT,
    RD_RDY,
    TX
  } mem_state_t;

endpackage

// File: rtl/spi_mem_array.sv
// Byte-wide storage for spi_mem.
// Synchronous write, combinational read, every location cleared by rst.
module spi_mem_array #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_mem.sv
// SPI-style memory target: decodes LSB-first cs/mosi frames, writes the byte
// array, and answers reads with a ready pulse followed by 8 miso bits.
module spi_mem
  import spi_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int READ_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic ready,
  output logic op_done,
  output logic addr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] lat_q, lat_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [7:0] sr_shift;
  logic [7:0] rd_data;
  logic       addr_ok_q, addr_ok_d;
  logic       mem_we;

  assign sr_shift  = {mosi, sr_q[7:1]};
  assign addr_ok_q = (32'(addr_q) < 32'(DEPTH));
  assign addr_ok_d = (32'(addr_d) < 32'(DEPTH));
  assign mem_we    = (state_q == COMMIT) && addr_ok_q;

  spi_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (addr_q[AW-1:0]),
    .wdata_i (sr_q),
    .raddr_i (addr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sr_d    = sr_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    tx_d    = tx_q;
    miso_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        sr_d  = '0;
        if (!cs) state_d = SYNC;
      end
      SYNC: begin
        state_d = cs ? IDLE : RX_HDR;
      end
      RX_HDR: begin
        if (cs) begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = '0;
        end else if (cnt_q == 4'd0) begin
          mode_d = mosi;
          cnt_d  = 4'd1;
        end else begin
          sr_d = sr_shift;
          if (cnt_q == 4'(FRAME_HDR_BITS - 1)) begin
            cnt_d  = '0;
            addr_d = sr_shift;
            if (mode_q == MODE_WR) begin
              state_d = RX_DATA;
            end else begin
              // RD_WAIT leaves on lat_q==1 so ready lands READ_LAT cycles
              // after the last header bit; READ_LAT==1 skips the wait entirely.
              lat_d   = 8'(READ_LAT - 1);
              state_d = (READ_LAT <= 1) ? RD_RDY : RD_WAIT;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (cs) begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = '0;
        end else begin
          sr_d = sr_shift;
          if (cnt_q == 4'(DATA_BITS - 1)) begin
            cnt_d   = '0;
            state_d = COMMIT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      RD_WAIT: begin
        if (lat_q <= 8'd1) begin
          lat_d   = '0;
          state_d = RD_RDY;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      RD_RDY: begin
        tx_d    = addr_ok_q ? rd_data : 8'h00;
        miso_d  = tx_d[0];
        cnt_d   = 4'd1;
        state_d = TX;
      end
      TX: begin
        if (cnt_q == 4'(DATA_BITS)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          miso_d = tx_q[cnt_q[2:0]];
          cnt_d  = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == RD_RDY);
    done_d  = (state_d == COMMIT);
    err_d   = ((state_d == RD_RDY) || (state_d == COMMIT)) && !addr_ok_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      sr_q    <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sr_q    <= sr_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign miso     = miso_q;
  assign ready    = ready_q;
  assign op_done  = done_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_spi_mem.sv
// Scoreboard bench for spi_mem: one instance at READ_LAT=1, one at READ_LAT=4.
// Frame senders push the expected response; per-scenario tasks pop and compare.
module tb_spi_mem;

  localparam int DEPTH = 32;
  localparam int LAT4  = 4;

  typedef struct packed {
    logic       seen;
    logic       is_rd;
    logic       err;
    logic [7:0] lat;
    logic [7:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs0 = 1'b1, mosi0 = 1'b0;
  logic cs1 = 1'b1, mosi1 = 1'b0;
  logic miso0, ready0, done0, err0;
  logic miso1, ready1, done1, err1;

  int vectors     = 0;
  int miscompares = 0;

  resp_t      sbq [$];
  logic [7:0] model_mem [2][256];

  always #5 clk = ~clk;

  spi_mem #(.DEPTH(DEPTH), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst), .cs(cs0), .mosi(mosi0),
    .miso(miso0), .ready(ready0), .op_done(done0), .addr_err(err0)
  );

  spi_mem #(.DEPTH(DEPTH), .READ_LAT(LAT4)) dut4 (
    .clk(clk), .rst(rst), .cs(cs1), .mosi(mosi1),
    .miso(miso1), .ready(ready1), .op_done(done1), .addr_err(err1)
  );

  function automatic logic o_ready(input int sel); return (sel == 0) ? ready0 : ready1; endfunction
  function automatic logic o_done(input int sel);  return (sel == 0) ? done0  : done1;  endfunction
  function automatic logic o_err(input int sel);   return (sel == 0) ? err0   : err1;   endfunction
  function automatic logic o_miso(input int sel);  return (sel == 0) ? miso0  : miso1;  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic c, input logic m);
    if (sel == 0) begin cs0 = c; mosi0 = m; end
    else          begin cs1 = c; mosi1 = m; end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 256; a++) model_mem[s][a] = 8'h00;
  endtask

  // Drives one full frame and pushes the response the model predicts.
  task automatic send_frame(input int sel, input logic wr, input logic [7:0] addr,
                            input logic [7:0] data, input logic keep_cs);
    logic [16:0] bits;
    resp_t e;
    int n;
    bits = {data, addr, wr};
    n = wr ? 17 : 9;
    drive(sel, 1'b0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < n; i++) begin
      drive(sel, 1'b0, bits[i]);
      tick();
    end
    drive(sel, keep_cs ? 1'b0 : 1'b1, 1'b0);
    e.seen  = 1'b1;
    e.is_rd = !wr;
    e.err   = (addr >= DEPTH);
    e.lat   = wr ? 8'd1 : ((sel == 0) ? 8'd1 : 8'(LAT4));
    e.data  = 8'h00;
    if (wr && addr < DEPTH) model_mem[sel][addr] = data;
    if (!wr && addr < DEPTH) e.data = model_mem[sel][addr];
    sbq.push_back(e);
  endtask

  // Observes the next ready/op_done pulse within budget cycles; no comparisons here.
  task automatic collect(input int sel, input int budget, output resp_t got);
    got = '0;
    for (int c = 1; c <= budget && !got.seen; c++) begin
      @(negedge clk);
      if (o_ready(sel) || o_done(sel)) begin
        got.seen  = 1'b1;
        got.is_rd = o_ready(sel);
        got.err   = o_err(sel);
        got.lat   = 8'(c);
      end
    end
    if (got.seen && got.is_rd) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        got.data[k] = o_miso(sel);
      end
    end
    if (got.seen) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({miso0, ready0, done0, err0, miso1, ready1, done1, err1} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hold: outputs=%b required 00000000",
               {miso0, ready0, done0, err0, miso1, ready1, done1, err1});
    end
    tick();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({miso0, ready0, done0, err0} !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_release: outputs=%b required 0000", {miso0, ready0, done0, err0});
    end
    $display("txn reset outputs=%b", {miso0, ready0, done0, err0});
  endtask

  task automatic test_write_read();
    resp_t exp, got;
    send_frame(0, 1'b1, 8'd3, 8'hA5, 1'b0);
    exp = sbq.pop_front(); collect(0, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL write3: got %p required %p", got, exp); end
    $display("txn write addr=3 data=a5 lat=%0d err=%0d", got.lat, got.err);

    send_frame(0, 1'b0, 8'd3, 8'h00, 1'b0);
    exp = sbq.pop_front(); collect(0, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL read3: got %p required %p", got, exp); end
    $display("txn read addr=3 data=%h lat=%0d err=%0d", got.data, got.lat, got.err);

    @(negedge clk);
    vectors++;
    if (miso0 !== 1'b0) begin miscompares++; $display("FAIL miso_idle: miso=%b required 0", miso0); end
  endtask

  task automatic test_out_of_range();
    resp_t exp, got;
    send_frame(0, 1'b1, 8'd40, 8'hFF, 1'b0);
    exp = sbq.pop_front(); collect(0, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL write40: got %p required %p", got, exp); end
    $display("txn write addr=40 data=ff lat=%0d err=%0d", got.lat, got.err);

    send_frame(0, 1'b0, 8'd40, 8'h00, 1'b0);
    exp = sbq.pop_front(); collect(0, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL read40: got %p required %p", got, exp); end
    $display("txn read addr=40 data=%h err=%0d", got.data, got.err);

    // 40 aliases to 8 if the address were truncated; location 8 must stay zero.
    send_frame(0, 1'b0, 8'd8, 8'h00, 1'b0);
    exp = sbq.pop_front(); collect(0, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL read8_alias: got %p required %p", got, exp); end
    $display("txn read addr=8 data=%h err=%0d", got.data, got.err);
  endtask

  task automatic test_abort();
    resp_t exp, got;
    drive(0, 1'b0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0, (i < 2) ? 1'b1 : 1'b0);
      tick();
    end
    drive(0, 1'b1, 1'b0);
    tick();
    collect(0, 30, got);
    vectors++;
    if (got.seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: pulse seen=%b rd=%b required no pulse", got.seen, got.is_rd);
    end
    $display("txn abort after 5 header bits seen=%0d", got.seen);

    send_frame(0, 1'b1, 8'd7, 8'h3C, 1'b0);
    exp = sbq.pop_front(); collect(0, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL write7: got %p required %p", got, exp); end
    $display("txn write addr=7 data=3c lat=%0d err=%0d", got.lat, got.err);

    send_frame(0, 1'b0, 8'd7, 8'h00, 1'b0);
    exp = sbq.pop_front(); collect(0, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL read7: got %p required %p", got, exp); end
    $display("txn read addr=7 data=%h err=%0d", got.data, got.err);
  endtask

  task automatic test_back_to_back();
    resp_t exp, got;
    send_frame(0, 1'b1, 8'd31, 8'h5A, 1'b1);
    exp = sbq.pop_front(); collect(0, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL b2b_write31: got %p required %p", got, exp); end
    $display("txn write addr=31 data=5a cs_held lat=%0d", got.lat);

    send_frame(0, 1'b0, 8'd31, 8'h00, 1'b0);
    exp = sbq.pop_front(); collect(0, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL b2b_read31: got %p required %p", got, exp); end
    $display("txn read addr=31 data=%h", got.data);

    send_frame(0, 1'b0, 8'd3, 8'h00, 1'b0);
    exp = sbq.pop_front(); collect(0, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL b2b_read3: got %p required %p", got, exp); end
    $display("txn read addr=3 data=%h", got.data);
  endtask

  task automatic test_lat4();
    resp_t exp, got;
    send_frame(1, 1'b1, 8'd7, 8'h3C, 1'b0);
    exp = sbq.pop_front(); collect(1, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL lat4_write7: got %p required %p", got, exp); end
    $display("txn lat4 write addr=7 data=3c lat=%0d", got.lat);

    send_frame(1, 1'b0, 8'd7, 8'h00, 1'b0);
    exp = sbq.pop_front(); collect(1, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL lat4_read7: got %p required %p", got, exp); end
    $display("txn lat4 read addr=7 data=%h lat=%0d", got.data, got.lat);
  endtask

  task automatic test_rst_mid_tx();
    resp_t exp, got;
    logic seen;
    send_frame(0, 1'b0, 8'd3, 8'h00, 1'b0);
    exp = sbq.pop_front();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = ready0;
    end
    vectors++;
    if (seen !== 1'b1) begin miscompares++; $display("FAIL rst_ready: ready=%b required 1", seen); end
    for (int k = 0; k < 3; k++) @(negedge clk);
    vectors++;
    if (miso0 !== exp.data[2]) begin
      miscompares++;
      $display("FAIL rst_tx_bit2: miso=%b required %b", miso0, exp.data[2]);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({miso0, ready0, done0, err0} !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_async: outputs=%b required 0000", {miso0, ready0, done0, err0});
    end
    $display("txn reset mid-tx outputs=%b", {miso0, ready0, done0, err0});
    clear_model();
    sbq.delete();
    drive(0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    send_frame(0, 1'b0, 8'd3, 8'h00, 1'b0);
    exp = sbq.pop_front(); collect(0, 40, got); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL post_rst_read3: got %p required %p", got, exp); end
    $display("txn read addr=3 after reset data=%h", got.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    test_reset();
    test_write_read();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_lat4();
    test_rst_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
